// File: rtl/decoder_scan.sv
// Registered one-hot decoder with enable: direct decode of x, or auto-scan
// that dwells DWELL cycles on each output and pulses wrap on roll-over.
module decoder_scan #(
   parameter int SEL_W = 3,
   parameter int DWELL = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  mode,
   input  logic                  load,
   input  logic [SEL_W-1:0]      x,
   output logic [2**SEL_W-1:0]   f,
   output logic [SEL_W-1:0]      idx,
   output logic                  wrap
);

   localparam int N     = 2 ** SEL_W;
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N - 1);

   typedef enum logic [1:0] {
      ACT_OFF,   // disabled: blank f, keep scan position
      ACT_SET,   // direct decode or scan load
      ACT_HOLD,  // scan, still dwelling on current index
      ACT_STEP   // scan, dwell expired: advance index
   } act_t;

   act_t               w_act;
   logic [N-1:0]       r_f,    w_f_nxt;
   logic [SEL_W-1:0]   r_idx,  w_idx_nxt, w_idx_inc;
   logic [CNT_W-1:0]   r_cnt,  w_cnt_nxt;
   logic               r_wrap, w_wrap_nxt;

   function automatic logic [N-1:0] dec(input logic [SEL_W-1:0] s);
      dec    = '0;
      dec[s] = 1'b1;
   endfunction

   assign w_idx_inc = r_idx + SEL_W'(1);

   always_comb begin
      if (!en)                     w_act = ACT_OFF;
      else if (!mode || load)      w_act = ACT_SET;
      else if (r_cnt != CNT_LAST)  w_act = ACT_HOLD;
      else                         w_act = ACT_STEP;
   end

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
      w_idx_nxt  = r_idx;
      w_cnt_nxt  = r_cnt;
      w_f_nxt    = r_f;
      w_wrap_nxt = 1'b0;
      unique case (w_act)
         ACT_OFF:  w_f_nxt = '0;
         ACT_SET: begin
            w_idx_nxt = x;
            w_cnt_nxt = '0;
            w_f_nxt   = dec(x);
         end
         ACT_HOLD: begin
            // Re-decoding here also restores f after an en=0 gap.
            w_cnt_nxt = r_cnt + CNT_W'(1);
            w_f_nxt   = dec(r_idx);
         end
         ACT_STEP: begin
            w_cnt_nxt  = '0;
            w_idx_nxt  = w_idx_inc;
            w_f_nxt    = dec(w_idx_inc);
            w_wrap_nxt = (r_idx == IDX_LAST);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         r_f    <= '0;
         r_idx  <= '0;
         r_cnt  <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_f    <= w_f_nxt;
         r_idx  <= w_idx_nxt;
         r_cnt  <= w_cnt_nxt;
         r_wrap <= w_wrap_nxt;
      end
   end

   assign f    = r_f;
   assign idx  = r_idx;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: three parameter variants share one stimulus stream and
// are compared each cycle against an integer model, plus literal spot checks.
module tb_decoder_scan;

   logic       clk = 1'b0;
   logic       rst, en, mode, load;
   logic [2:0] x;

   logic [7:0] f_a, f_b;
   logic [3:0] f_c;
   logic [2:0] idx_a, idx_b;
   logic [1:0] idx_c;
   logic       wrap_a, wrap_b, wrap_c;

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_on = 1'b0;

   // Model state per variant: 0 = (3,4), 1 = (3,2), 2 = (2,1)
   int m_idx [3];
   int m_held[3];
   int m_f   [3];
   int m_wrap[3];

   always #5 clk = ~clk;

   decoder_scan #(.SEL_W(3), .DWELL(4)) u_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .x(x),
      .f(f_a), .idx(idx_a), .wrap(wrap_a));
   decoder_scan #(.SEL_W(3), .DWELL(2)) u_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .x(x),
      .f(f_b), .idx(idx_b), .wrap(wrap_b));
   decoder_scan #(.SEL_W(2), .DWELL(1)) u_c (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .x(x[1:0]),
      .f(f_c), .idx(idx_c), .wrap(wrap_c));

   function automatic int outs_of(int k);
      return (k == 2) ? 4 : 8;
   endfunction

   function automatic int dwell_of(int k);
      case (k)
         0:       return 4;
         1:       return 2;
         default: return 1;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: m_held counts cycles already spent on the current index.
   function automatic void model_step(int k);
      int n;
      n = outs_of(k);
      if (rst) begin
         m_idx[k] = 0; m_held[k] = 0; m_f[k] = 0; m_wrap[k] = 0;
      end else if (!en) begin
         m_f[k] = 0; m_wrap[k] = 0;
      end else if (!mode || load) begin
         m_idx[k]  = int'(x) % n;
         m_held[k] = 0;
         m_f[k]    = 1 << m_idx[k];
         m_wrap[k] = 0;
      end else begin
         m_wrap[k] = 0;
         if (m_held[k] + 1 >= dwell_of(k)) begin
            m_held[k] = 0;
            if (m_idx[k] == n - 1) m_wrap[k] = 1;
            m_idx[k] = (m_idx[k] + 1) % n;
         end else begin
            m_held[k] = m_held[k] + 1;
         end
         m_f[k] = 1 << m_idx[k];
      end
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) model_step(k);
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         check("A.f",    32'(f_a),    m_f[0]);
         check("A.idx",  32'(idx_a),  m_idx[0]);
         check("A.wrap", 32'(wrap_a), m_wrap[0]);
         check("B.f",    32'(f_b),    m_f[1]);
         check("B.idx",  32'(idx_b),  m_idx[1]);
         check("B.wrap", 32'(wrap_b), m_wrap[1]);
         check("C.f",    32'(f_c),    m_f[2]);
         check("C.idx",  32'(idx_c),  m_idx[2]);
         check("C.wrap", 32'(wrap_c), m_wrap[2]);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; mode = 1'b0; load = 1'b0; x = 3'd5;

      // Reset held two cycles, then direct decode of x=5
      step(1);
      cmp_on = 1'b1;
      step(1);
      check("rst.f",    32'(f_a),    32'h00);
      check("rst.idx",  32'(idx_a),  32'd0);
      check("rst.wrap", 32'(wrap_a), 32'd0);
      rst = 1'b0;
      step(1);
      check("direct5.f",   32'(f_a),   32'h20);
      check("direct5.idx", 32'(idx_a), 32'd5);

      // Direct sweep, then disable
      for (int v = 0; v < 8; v++) begin
         x = 3'(v);
         step(1);
         check("sweep.f", 32'(f_a), 32'(1 << v));
      end
      en = 1'b0;
      step(1);
      check("dis.f",   32'(f_a),   32'h00);
      check("dis.idx", 32'(idx_a), 32'd7);

      // Scan from reset: after 16 edges B and C wrap, A sits on index 4
      rst = 1'b1; en = 1'b1;
      step(1);
      rst = 1'b0; mode = 1'b1;
      step(1);
      check("scanB.first", 32'(f_b), 32'h01);
      step(15);
      check("scanB.f16",    32'(f_b),    32'h01);
      check("scanB.wrap16", 32'(wrap_b), 32'd1);
      check("scanA.f16",    32'(f_a),    32'h10);
      check("scanC.f16",    32'(f_c),    32'h1);
      check("scanC.wrap16", 32'(wrap_c), 32'd1);
      step(1);
      check("scanB.wrapone", 32'(wrap_b), 32'd0);

      // B reaches idx 6 with a fresh dwell, then a 3-cycle enable gap
      step(11);
      check("gap.pre", 32'(f_b), 32'h40);
      en = 1'b0;
      step(3);
      check("gap.f",   32'(f_b),   32'h00);
      check("gap.idx", 32'(idx_b), 32'd6);
      en = 1'b1;
      step(1);
      check("resume.f", 32'(f_b), 32'h40);
      step(1);
      check("resume.adv",  32'(f_b),    32'h80);
      check("resume.wrap", 32'(wrap_b), 32'd0);

      // Scan load of 7, then A dwells 4 cycles before wrapping to 0
      load = 1'b1; x = 3'd7;
      step(1);
      check("load.f",    32'(f_a),    32'h80);
      check("load.idx",  32'(idx_a),  32'd7);
      check("load.wrap", 32'(wrap_a), 32'd0);
      load = 1'b0;
      step(3);
      check("load.hold", 32'(f_a), 32'h80);
      step(1);
      check("load.wrapf", 32'(f_a),    32'h01);
      check("load.wrap",  32'(wrap_a), 32'd1);

      // Reset mid-sweep
      step(2);
      rst = 1'b1;
      step(1);
      check("midrst.f",   32'(f_c),   32'h0);
      check("midrst.idx", 32'(idx_c), 32'd0);
      rst = 1'b0;

      // Randomised traffic; the per-cycle compare checks everything
      for (int i = 0; i < 3000; i++) begin
         rst  = ($urandom_range(0, 99) == 0);
         en   = ($urandom_range(0, 9) != 0);
         mode = ($urandom_range(0, 7) != 0);
         load = ($urandom_range(0, 15) == 0);
         x    = 3'($urandom);
         step(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
